// File: rtl/clkmon.sv
// Frequency/lock monitor: counts synchronised toggle transitions from a generated clock
// over a fixed gate window and qualifies a downstream reset once the clock is stable.
module clkmon #(
    parameter int GATE_CYCLES = 1000,
    parameter int EXPECT      = 200,
    parameter int TOLERANCE   = 2,
    parameter int STOP_CYCLES = 64,
    parameter int OK_WINDOWS  = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   mon_toggle,
    input  logic                   lost_lock_clr,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   count_valid,
    output logic                   freq_ok,
    output logic                   clk_stopped,
    output logic                   locked,
    output logic                   lost_lock,
    output logic                   out_reset
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int STOP_W = $clog2(STOP_CYCLES + 1);
    localparam int OK_W   = $clog2(OK_WINDOWS + 1);
    localparam int TOL_LO = (EXPECT > TOLERANCE) ? (EXPECT - TOLERANCE) : 0;
    localparam int TOL_HI = EXPECT + TOLERANCE;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [STOP_W-1:0] STOP_MAX  = STOP_W'(STOP_CYCLES);
    localparam logic [OK_W-1:0]   OK_LAST   = OK_W'(OK_WINDOWS - 1);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                       input logic inc);
        if (inc && (v != '1)) return v + 1'b1;
        return v;
    endfunction

    function automatic logic in_tol(input logic [COUNT_WIDTH-1:0] c);
        logic [31:0] c32;
        c32 = 32'(c);
        return (c32 >= 32'(TOL_LO)) && (c32 <= 32'(TOL_HI));
    endfunction

    logic                   s1_q, s2_q, s3_q;
    logic                   tog_edge;
    logic [GATE_W-1:0]      gate_q;
    logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [STOP_W-1:0]      stop_q, stop_d;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   count_valid_q, freq_ok_q, clk_stopped_q;
    state_t                 state_q;
    logic [OK_W-1:0]        ok_cnt_q;
    logic                   locked_q, lost_lock_q;
    logic                   lock_loss;

    // The synchroniser keeps sampling while disabled so re-enable never sees a stale level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= mon_toggle;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign tog_edge = s2_q ^ s3_q;

    always_comb begin
        edge_cnt_d = sat_inc(edge_cnt_q, tog_edge);
        stop_d     = stop_q;
        if (tog_edge)                stop_d = '0;
        else if (stop_q != STOP_MAX) stop_d = stop_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            stop_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            freq_ok_q     <= 1'b0;
            clk_stopped_q <= 1'b0;
        end else if (!enable) begin
            gate_q        <= '0;
            edge_cnt_q    <= '0;
            stop_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            freq_ok_q     <= 1'b0;
            clk_stopped_q <= 1'b0;
        end else begin
            stop_q        <= stop_d;
            clk_stopped_q <= (stop_q == STOP_MAX) && !tog_edge;
            // The terminal cycle's own edge belongs to the closing window.
            if (gate_q == GATE_LAST) begin
                gate_q        <= '0;
                edge_cnt_q    <= '0;
                count_q       <= edge_cnt_d;
                count_valid_q <= 1'b1;
                freq_ok_q     <= in_tol(edge_cnt_d);
            end else begin
                gate_q        <= gate_q + 1'b1;
                edge_cnt_q    <= edge_cnt_d;
                count_valid_q <= 1'b0;
            end
        end
    end

    assign lock_loss = enable && (state_q == LOCKED) &&
                       (clk_stopped_q || (count_valid_q && !freq_ok_q));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= UNLOCKED;
            ok_cnt_q    <= '0;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            if (!enable) begin
                state_q  <= UNLOCKED;
                ok_cnt_q <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    UNLOCKED: begin
                        if (clk_stopped_q) begin
                            ok_cnt_q <= '0;
                        end else if (count_valid_q) begin
                            if (!freq_ok_q) begin
                                ok_cnt_q <= '0;
                            end else if (ok_cnt_q == OK_LAST) begin
                                ok_cnt_q <= '0;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                ok_cnt_q <= ok_cnt_q + 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (lock_loss) begin
                            ok_cnt_q <= '0;
                            state_q  <= UNLOCKED;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        ok_cnt_q <= '0;
                        state_q  <= UNLOCKED;
                        locked_q <= 1'b0;
                    end
                endcase
                // A lock loss in the same cycle as a clear leaves the flag set.
                if (lock_loss)          lost_lock_q <= 1'b1;
                else if (lost_lock_clr) lost_lock_q <= 1'b0;
            end
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign freq_ok     = freq_ok_q;
    assign clk_stopped = clk_stopped_q;
    assign locked      = locked_q;
    assign lost_lock   = lost_lock_q;
    assign out_reset   = ~locked_q;

endmodule

// File: tb/tb_clkmon.sv
// Directed bench for clkmon: per-window transition counts are queued as they are driven
// and checked against count/freq_ok when the window closes.
module tb_clkmon;

    localparam int TOL_LO = 198;
    localparam int TOL_HI = 202;

    logic        clk = 1'b0;
    logic        reset_n, enable, mon_toggle, lost_lock_clr;
    logic [15:0] count;
    logic        count_valid, freq_ok, clk_stopped, locked, lost_lock, out_reset;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_q[$];
    int sum_counts = 0;
    int lat;
    int w;
    int cyc;
    bit seen;

    always #5 clk = ~clk;

    clkmon dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mon_toggle   (mon_toggle),
        .lost_lock_clr(lost_lock_clr),
        .count        (count),
        .count_valid  (count_valid),
        .freq_ok      (freq_ok),
        .clk_stopped  (clk_stopped),
        .locked       (locked),
        .lost_lock    (lost_lock),
        .out_reset    (out_reset)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_close(input string tag);
        int e;
        e = exp_q.pop_front();
        check({tag, " count"}, 32'(count), 32'(e));
        check({tag, " freq_ok"}, 32'(freq_ok), 32'((e >= TOL_LO) && (e <= TOL_HI)));
        sum_counts += int'(count);
    endtask

    task automatic wait_close(input string tag, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        for (int k = 1; k <= 1200; k++) begin
            tick();
            waited = k;
            if (count_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, " window closed"}, 32'(got), 32'd1);
        if (got) compare_close(tag);
        else void'(exp_q.pop_front());
    endtask

    // Entered #1 after a clock edge; n transitions spread over the window, plus an
    // optional one timed so its edge falls on the gate terminal cycle.
    task automatic drive_window(input string tag, input int n, input bit extra, output int lt);
        int idx;
        int wt;
        idx = 0;
        lt = -1;
        exp_q.push_back(n + int'(extra));
        for (int t = 0; t < 998; t++) begin
            if (idx < n && t == 8 + (idx * 980) / n) begin
                mon_toggle = ~mon_toggle;
                idx++;
            end
            if (extra && t == 997) mon_toggle = ~mon_toggle;
            tick();
            if (count_valid) begin
                lt = t + 1;
                break;
            end
        end
        if (lt < 0) begin
            wait_close(tag, wt);
            lt = 998 + wt;
        end else begin
            compare_close(tag);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        mon_toggle    = 1'b0;
        lost_lock_clr = 1'b0;
        repeat (3) tick();
        check("rst count", 32'(count), 0);
        check("rst count_valid", 32'(count_valid), 0);
        check("rst freq_ok", 32'(freq_ok), 0);
        check("rst clk_stopped", 32'(clk_stopped), 0);
        check("rst locked", 32'(locked), 0);
        check("rst lost_lock", 32'(lost_lock), 0);
        check("rst out_reset", 32'(out_reset), 1);

        reset_n = 1'b1;
        tick();
        enable = 1'b1;

        // Nominal clock: lock after the fourth good window
        for (int i = 0; i < 4; i++) begin
            drive_window("nominal", 200, 1'b0, lat);
            if (i == 0) check("first window latency", 32'(lat), 1000);
            check("nominal locked at close", 32'(locked), 0);
            check("nominal out_reset at close", 32'(out_reset), 1);
        end
        tick();
        check("nominal locked", 32'(locked), 1);
        check("nominal out_reset", 32'(out_reset), 0);
        check("nominal lost_lock", 32'(lost_lock), 0);

        // Tolerance boundaries while locked
        drive_window("tol198", 198, 1'b0, lat);
        tick();
        check("tol198 locked", 32'(locked), 1);
        drive_window("tol202", 202, 1'b0, lat);
        tick();
        check("tol202 locked", 32'(locked), 1);
        drive_window("tol203", 203, 1'b0, lat);
        check("tol203 locked at close", 32'(locked), 1);
        lost_lock_clr = 1'b1;
        tick();
        lost_lock_clr = 1'b0;
        check("tol203 locked", 32'(locked), 0);
        check("tol203 out_reset", 32'(out_reset), 1);
        check("collision lost_lock", 32'(lost_lock), 1);
        lost_lock_clr = 1'b1;
        tick();
        lost_lock_clr = 1'b0;
        check("clear lost_lock", 32'(lost_lock), 0);
        drive_window("tol197", 197, 1'b0, lat);
        tick();
        check("tol197 locked", 32'(locked), 0);
        check("tol197 lost_lock", 32'(lost_lock), 0);

        for (int i = 0; i < 4; i++) drive_window("relock1", 200, 1'b0, lat);
        tick();
        check("relock1 locked", 32'(locked), 1);

        // Stopped clock: one last transition, then silence
        exp_q.push_back(2);
        mon_toggle = ~mon_toggle;
        cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            cyc = k;
            if (clk_stopped) break;
        end
        check("stop detect cycles", 32'(cyc), 68);
        check("stop locked still", 32'(locked), 1);
        tick();
        check("stop locked", 32'(locked), 0);
        check("stop out_reset", 32'(out_reset), 1);
        check("stop lost_lock", 32'(lost_lock), 1);
        repeat (31) tick();
        mon_toggle = ~mon_toggle;
        tick();
        tick();
        check("resume clk_stopped held", 32'(clk_stopped), 1);
        tick();
        check("resume clk_stopped clear", 32'(clk_stopped), 0);
        wait_close("stopped", w);

        // Relock; last three windows each carry an edge on the terminal cycle
        drive_window("relock2", 200, 1'b0, lat);
        sum_counts = 0;
        drive_window("term1", 199, 1'b1, lat);
        drive_window("term2", 197, 1'b1, lat);
        drive_window("term3", 201, 1'b1, lat);
        check("terminal edge total", 32'(sum_counts), 600);
        check("relock2 locked at close", 32'(locked), 0);
        tick();
        check("relock2 locked", 32'(locked), 1);

        // Enable dropped mid-window
        for (int t = 0; t < 400; t++) begin
            if (t % 5 == 0) mon_toggle = ~mon_toggle;
            tick();
        end
        enable = 1'b0;
        tick();
        check("dis count", 32'(count), 0);
        check("dis count_valid", 32'(count_valid), 0);
        check("dis freq_ok", 32'(freq_ok), 0);
        check("dis clk_stopped", 32'(clk_stopped), 0);
        check("dis locked", 32'(locked), 0);
        check("dis out_reset", 32'(out_reset), 1);
        check("dis lost_lock held", 32'(lost_lock), 1);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (count_valid) seen = 1'b1;
        end
        check("dis no count_valid", 32'(seen), 0);
        enable = 1'b1;
        drive_window("reenable", 200, 1'b0, lat);
        check("reenable latency", 32'(lat), 1000);
        check("reenable lost_lock", 32'(lost_lock), 1);
        for (int i = 0; i < 3; i++) drive_window("relock3", 200, 1'b0, lat);
        tick();
        check("relock3 locked", 32'(locked), 1);

        // Asynchronous reset mid-window
        for (int t = 0; t < 300; t++) begin
            if (t % 5 == 0) mon_toggle = ~mon_toggle;
            tick();
        end
        reset_n = 1'b0;
        #2;
        check("arst count", 32'(count), 0);
        check("arst count_valid", 32'(count_valid), 0);
        check("arst freq_ok", 32'(freq_ok), 0);
        check("arst clk_stopped", 32'(clk_stopped), 0);
        check("arst locked", 32'(locked), 0);
        check("arst lost_lock", 32'(lost_lock), 0);
        check("arst out_reset", 32'(out_reset), 1);
        mon_toggle = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        drive_window("post reset", 200, 1'b0, lat);
        check("post reset latency", 32'(lat), 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
